// File: rtl/reflet_bus_pkg.sv
// Shared constants and helpers for the Reflet system-bus matrix and its address decoder.
package reflet_bus_pkg;

   localparam int FAULT_CNT_W  = 8;
   localparam int STRETCH_W    = 8;

   localparam int DEF_WORDSIZE = 16;
   localparam int DEF_SLAVES   = 4;

   // Slave i occupies bits [i*WORDSIZE +: WORDSIZE]; the rightmost entry is slave 0.
   localparam logic [DEF_SLAVES*DEF_WORDSIZE-1:0] DEF_BASE_ADDRS =
      {16'hFF00, 16'h8000, 16'h0000, 16'h0000};
   localparam logic [DEF_SLAVES*DEF_WORDSIZE-1:0] DEF_ADDR_MASKS =
      {16'hFF00, 16'h8000, 16'h8000, 16'hFFFF};

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reflet_bus_decoder.sv
// Combinational base/mask region decoder: one-hot enable, winning index and hit flag.
// On overlapping regions the lowest slave index wins.
module reflet_bus_decoder
   import reflet_bus_pkg::*;
#(
   parameter int                         WORDSIZE   = DEF_WORDSIZE,
   parameter int                         SLAVES     = DEF_SLAVES,
   parameter logic [SLAVES*WORDSIZE-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
   parameter logic [SLAVES*WORDSIZE-1:0] ADDR_MASKS = DEF_ADDR_MASKS
) (
   input  logic                       valid_i,
   input  logic [WORDSIZE-1:0]        addr_i,
   output logic [SLAVES-1:0]          enable_o,
   output logic [sel_w(SLAVES)-1:0]   index_o,
   output logic                       hit_o
);

   localparam int SW = sel_w(SLAVES);

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      enable_o = '0;
      index_o  = '0;
      hit_o    = 1'b0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if (valid_i &&
             ((addr_i & ADDR_MASKS[i*WORDSIZE +: WORDSIZE]) == BASE_ADDRS[i*WORDSIZE +: WORDSIZE])) begin
            enable_o    = '0;
            enable_o[i] = 1'b1;
            index_o     = SW'(i);
            hit_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reflet_bus_matrix.sv
// Reflet system-bus interconnect: region decode, registered read-data select, reset stretcher
// and first-fault capture. Define REFLET_BUS_FAULT_CNT_EN to build the saturating fault counter.
module reflet_bus_matrix
   import reflet_bus_pkg::*;
#(
   parameter int                         WORDSIZE      = DEF_WORDSIZE,
   parameter int                         SLAVES        = DEF_SLAVES,
   parameter logic [SLAVES*WORDSIZE-1:0] BASE_ADDRS    = DEF_BASE_ADDRS,
   parameter logic [SLAVES*WORDSIZE-1:0] ADDR_MASKS    = DEF_ADDR_MASKS,
   parameter int                         RESET_STRETCH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         sys_reset,
   input  logic                         cpu_valid,
   input  logic [WORDSIZE-1:0]          cpu_addr,
   input  logic [WORDSIZE-1:0]          cpu_wdata,
   input  logic                         cpu_write_en,
   output logic [WORDSIZE-1:0]          cpu_rdata,
   output logic [SLAVES-1:0]            slv_enable,
   output logic [SLAVES-1:0]            slv_write_en,
   output logic [WORDSIZE-1:0]          slv_addr,
   output logic [WORDSIZE-1:0]          slv_wdata,
   input  logic [SLAVES*WORDSIZE-1:0]   slv_rdata,
   output logic                         fault_valid,
   output logic [WORDSIZE-1:0]          fault_addr,
   output logic                         fault_write,
   output logic                         fault_irq,
   input  logic                         fault_clear,
   output logic [FAULT_CNT_W-1:0]       fault_count
);

   localparam int SW = sel_w(SLAVES);

   logic [STRETCH_W-1:0] stretch_q, stretch_d;
   logic                 sys_reset_q, sys_reset_d;

   logic                 dec_valid;
   logic                 dec_hit;
   logic [SLAVES-1:0]    dec_enable;
   logic [SW-1:0]        dec_index;
   logic                 unmapped;

   logic [SW-1:0]        sel_idx_q, sel_idx_d;
   logic                 sel_vld_q, sel_vld_d;

   logic                 fault_valid_q, fault_valid_d;
   logic [WORDSIZE-1:0]  fault_addr_q, fault_addr_d;
   logic                 fault_write_q, fault_write_d;
   logic                 fault_irq_q, fault_irq_d;

   // sys_reset drops on the RESET_STRETCH-th rising edge after reset is released.
   always_comb begin
      stretch_d   = stretch_q;
      sys_reset_d = sys_reset_q;
      if (sys_reset_q) begin
         if (stretch_q == STRETCH_W'(RESET_STRETCH - 1)) begin
            sys_reset_d = 1'b0;
         end else begin
            stretch_d = stretch_q + STRETCH_W'(1);
         end
      end
   end

   assign dec_valid = cpu_valid & ~sys_reset_q;
   assign unmapped  = dec_valid & ~dec_hit;

   reflet_bus_decoder #(
      .WORDSIZE   (WORDSIZE),
      .SLAVES     (SLAVES),
      .BASE_ADDRS (BASE_ADDRS),
      .ADDR_MASKS (ADDR_MASKS)
   ) u_decoder (
      .valid_i  (dec_valid),
      .addr_i   (cpu_addr),
      .enable_o (dec_enable),
      .index_o  (dec_index),
      .hit_o    (dec_hit)
   );

   assign slv_enable   = dec_enable;
   assign slv_write_en = dec_enable & {SLAVES{cpu_write_en}};
   assign slv_wdata    = cpu_wdata;

   always_comb begin
      slv_addr = '0;
      if (dec_hit) begin
         slv_addr = cpu_addr & ~ADDR_MASKS[dec_index*WORDSIZE +: WORDSIZE];
      end
   end

   // Slaves answer one cycle after the access, so the select is registered alongside.
   assign sel_idx_d = dec_index;
   assign sel_vld_d = dec_hit & ~cpu_write_en;

   always_comb begin
      cpu_rdata = '0;
      if (sel_vld_q) begin
         cpu_rdata = slv_rdata[sel_idx_q*WORDSIZE +: WORDSIZE];
      end
   end

   // First fault is kept until cleared; a clear coinciding with a new fault re-arms capture.
   always_comb begin
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_write_d = fault_write_q;
      fault_irq_d   = 1'b0;
      if (fault_clear) begin
         fault_valid_d = 1'b0;
      end
      if (unmapped && (!fault_valid_q || fault_clear)) begin
         fault_valid_d = 1'b1;
         fault_addr_d  = cpu_addr;
         fault_write_d = cpu_write_en;
         fault_irq_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stretch_q     <= '0;
         sys_reset_q   <= 1'b1;
         sel_idx_q     <= '0;
         sel_vld_q     <= 1'b0;
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
         fault_write_q <= 1'b0;
         fault_irq_q   <= 1'b0;
      end else begin
         stretch_q     <= stretch_d;
         sys_reset_q   <= sys_reset_d;
         sel_idx_q     <= sel_idx_d;
         sel_vld_q     <= sel_vld_d;
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_write_q <= fault_write_d;
         fault_irq_q   <= fault_irq_d;
      end
   end

   assign sys_reset   = sys_reset_q;
   assign fault_valid = fault_valid_q;
   assign fault_addr  = fault_addr_q;
   assign fault_write = fault_write_q;
   assign fault_irq   = fault_irq_q;

`ifdef REFLET_BUS_FAULT_CNT_EN
   logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (fault_clear) begin
         fault_cnt_d = unmapped ? FAULT_CNT_W'(1) : '0;
      end else if (unmapped && (fault_cnt_q != '1)) begin
         fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_cnt_q <= '0;
      end else begin
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign fault_count = fault_cnt_q;
`else
   assign fault_count = '0;
`endif

endmodule

// File: tb/tb_reflet_bus_matrix.sv
// Bench for reflet_bus_matrix: a default 16-bit/4-slave map and a 32-bit/2-slave map side by side.
module tb_reflet_bus_matrix;

`ifdef REFLET_BUS_FAULT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   logic va, vb;
   logic [31:0] addr, wdata;
   logic we, clr;

   logic        sr_a, fv_a, fw_a, irq_a;
   logic [15:0] rd_a, sa_a, wd_a, fa_a;
   logic [3:0]  en_a, wen_a;
   logic [7:0]  fc_a;
   logic [63:0] rdata_a;

   logic        sr_b, fv_b, fw_b, irq_b;
   logic [31:0] rd_b, sa_b, wd_b, fa_b;
   logic [1:0]  en_b, wen_b;
   logic [7:0]  fc_b;
   logic [63:0] rdata_b;

   int n_vec = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reflet_bus_matrix #(
      .RESET_STRETCH (16)
   ) u_dut_a (
      .clk (clk), .reset (reset), .sys_reset (sr_a),
      .cpu_valid (va), .cpu_addr (addr[15:0]), .cpu_wdata (wdata[15:0]), .cpu_write_en (we),
      .cpu_rdata (rd_a), .slv_enable (en_a), .slv_write_en (wen_a), .slv_addr (sa_a),
      .slv_wdata (wd_a), .slv_rdata (rdata_a), .fault_valid (fv_a), .fault_addr (fa_a),
      .fault_write (fw_a), .fault_irq (irq_a), .fault_clear (clr), .fault_count (fc_a)
   );

   reflet_bus_matrix #(
      .WORDSIZE      (32),
      .SLAVES        (2),
      .BASE_ADDRS    ({32'h0000_4000, 32'h0000_0000}),
      .ADDR_MASKS    ({32'hFFFF_C000, 32'hFFFF_C000}),
      .RESET_STRETCH (3)
   ) u_dut_b (
      .clk (clk), .reset (reset), .sys_reset (sr_b),
      .cpu_valid (vb), .cpu_addr (addr), .cpu_wdata (wdata), .cpu_write_en (we),
      .cpu_rdata (rd_b), .slv_enable (en_b), .slv_write_en (wen_b), .slv_addr (sa_b),
      .slv_wdata (wd_b), .slv_rdata (rdata_b), .fault_valid (fv_b), .fault_addr (fa_b),
      .fault_write (fw_b), .fault_irq (irq_b), .fault_clear (clr), .fault_count (fc_b)
   );

   typedef struct {
      logic        b;     // 0: 16-bit map, 1: 32-bit map
      logic        v;
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      logic        clr;
      logic [3:0]  en;
      logic [3:0]  wen;
      logic [31:0] sa;
      logic [31:0] rd;    // cpu_rdata one cycle later
      logic        fv;
      logic [31:0] fa;
      logic        fw;
      logic        irq;
      logic [7:0]  cnt;   // fault_count when the counter is built
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input int k, input vec_t t);
      va    = t.v & ~t.b;
      vb    = t.v & t.b;
      addr  = t.a;
      wdata = t.wd;
      we    = t.we;
      clr   = t.clr;
      #2;
      chk("slv_enable",   k, t.b ? {30'd0, en_b}  : {28'd0, en_a},  {28'd0, t.en});
      chk("slv_write_en", k, t.b ? {30'd0, wen_b} : {28'd0, wen_a}, {28'd0, t.wen});
      chk("slv_addr",     k, t.b ? sa_b : {16'd0, sa_a}, t.sa);
      chk("slv_wdata",    k, t.b ? wd_b : {16'd0, wd_a}, t.b ? t.wd : {16'd0, t.wd[15:0]});
      @(posedge clk);
      #1;
      chk("cpu_rdata",   k, t.b ? rd_b : {16'd0, rd_a}, t.rd);
      chk("fault_valid", k, {31'd0, t.b ? fv_b : fv_a}, {31'd0, t.fv});
      chk("fault_addr",  k, t.b ? fa_b : {16'd0, fa_a}, t.fa);
      chk("fault_write", k, {31'd0, t.b ? fw_b : fw_a}, {31'd0, t.fw});
      chk("fault_irq",   k, {31'd0, t.b ? irq_b : irq_a}, {31'd0, t.irq});
      chk("fault_count", k, {24'd0, t.b ? fc_b : fc_a}, {24'd0, CNT_EN ? t.cnt : 8'd0});
   endtask

   task automatic count_stretch(output int fall_a, output int fall_b);
      fall_a = 0;
      fall_b = 0;
      for (int k = 1; k <= 40 && (fall_a == 0 || fall_b == 0); k++) begin
         @(posedge clk);
         #1;
         if (fall_a == 0 && !sr_a) fall_a = k;
         if (fall_b == 0 && !sr_b) fall_b = k;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_sys_reset_a"}, 0, {31'd0, sr_a}, 32'd1);
      chk({tag, "_sys_reset_b"}, 0, {31'd0, sr_b}, 32'd1);
      chk({tag, "_rdata_a"},     0, {16'd0, rd_a}, 32'd0);
      chk({tag, "_rdata_b"},     0, rd_b, 32'd0);
      chk({tag, "_fv_b"},        0, {31'd0, fv_b}, 32'd0);
      chk({tag, "_fa_b"},        0, fa_b, 32'd0);
      chk({tag, "_fw_b"},        0, {31'd0, fw_b}, 32'd0);
      chk({tag, "_irq_b"},       0, {31'd0, irq_b}, 32'd0);
      chk({tag, "_fc_b"},        0, {24'd0, fc_b}, 32'd0);
      chk({tag, "_fv_a"},        0, {31'd0, fv_a}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall_a, fall_b;

      rdata_a = {16'hDDDD, 16'h2222, 16'h1111, 16'hAAAA};
      rdata_b = {32'h2222_2222, 32'h1111_1111};

      //                b     v     addr           wdata          we    clr   en       wen      saddr          rdata          fv    faddr          fw    irq   cnt
      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 32'h0000_0004, 32'h0000_1111, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b1, 32'h0000_8002, 32'h0000_0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 32'h0000_0002, 32'h0000_2222, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_FF1A, 32'h0000_BEEF, 1'b1, 1'b0, 4'b0100, 4'b0100, 32'h0000_7F1A, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0000_0000, 32'h0000_AAAA, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_5A5A, 1'b1, 1'b0, 4'b0010, 4'b0010, 32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[6]  = '{1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 32'h0000_7FFF, 32'h0000_2222, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[7]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0000_0004, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[8]  = '{1'b1, 1'b1, 32'h0000_4002, 32'h0000_0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 32'h0000_0002, 32'h2222_2222, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0};
      tbl[9]  = '{1'b1, 1'b1, 32'h0000_9000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_9000, 1'b0, 1'b1, 8'd1};
      tbl[10] = '{1'b1, 1'b1, 32'h0000_A000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_9000, 1'b0, 1'b0, 8'd2};
      tbl[11] = '{1'b1, 1'b1, 32'h0000_C000, 32'h0000_1234, 1'b1, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_C000, 1'b1, 1'b1, 8'd1};
      tbl[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_C000, 1'b1, 1'b0, 8'd0};
      tbl[13] = '{1'b1, 1'b1, 32'h0000_4010, 32'h0000_CAFE, 1'b1, 1'b0, 4'b0010, 4'b0010, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_C000, 1'b1, 1'b0, 8'd0};
      tbl[14] = '{1'b1, 1'b1, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b1, 1'b1, 8'd1};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 8'd1};
      tbl[16] = '{1'b1, 1'b1, 32'h0000_4000, 32'h0000_0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 32'h0000_0000, 32'h2222_2222, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 8'd1};

      reset = 1'b1;
      va = 1'b0; vb = 1'b0; addr = '0; wdata = '0; we = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("rst");

      // Release; an access in the first stretched cycle must be ignored by both maps.
      reset = 1'b0;
      va = 1'b1; vb = 1'b1; addr = 32'h0000_9000;
      #1;
      chk("ignored_en_a", 0, {28'd0, en_a}, 32'd0);
      chk("ignored_en_b", 0, {30'd0, en_b}, 32'd0);
      @(posedge clk);
      #1;
      va = 1'b0; vb = 1'b0; addr = '0;
      chk("ignored_fv_b",  0, {31'd0, fv_b}, 32'd0);
      chk("ignored_irq_b", 0, {31'd0, irq_b}, 32'd0);
      chk("ignored_rd_a",  0, {16'd0, rd_a}, 32'd0);
      count_stretch(fall_a, fall_b);
      chk("stretch_a", 0, fall_a + 1, 32'd16);
      chk("stretch_b", 0, fall_b + 1, 32'd3);

      // Reset reasserted after 8 edges of a fresh stretch restarts the count.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_stretch_a", 0, {31'd0, sr_a}, 32'd1);
      reset = 1'b1;
      #3;
      reset = 1'b0;
      count_stretch(fall_a, fall_b);
      chk("restart_a", 0, fall_a, 32'd16);
      chk("restart_b", 0, fall_b, 32'd3);

      for (int k = 0; k < 17; k++) begin
         apply(k, tbl[k]);
      end

      // Long run of unmapped reads: first fault is held, counter saturates.
      vb = 1'b1; addr = 32'h0000_9000; we = 1'b0; clr = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      vb = 1'b0;
      chk("sat_count", 0, {24'd0, fc_b}, CNT_EN ? 32'h0000_00FF : 32'd0);
      chk("sat_fv",    0, {31'd0, fv_b}, 32'd1);
      chk("sat_fa",    0, fa_b, 32'h0001_0000);
      chk("sat_irq",   0, {31'd0, irq_b}, 32'd0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_count", 0, {24'd0, fc_b}, 32'd0);
      chk("clr_fv",    0, {31'd0, fv_b}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
